// File: rtl/instr_mem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory program loader.
package loader_pkg;

   // Width of the little-endian length field that opens each frame
   localparam int LEN_WIDTH = 16;

   // Width of the running payload checksum (sum mod 256)
   localparam int SUM_WIDTH = 8;

   // Loader control states
   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } state_t;

endpackage : loader_pkg

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake plus byte-wide instruction-memory write port.
// The loader is the slave of the stream and drives the memory write side.
interface instr_mem_loader_if #(
   parameter int ADDR_WIDTH = 12
);

   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  byte_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;

   // Stream source / memory observer side
   modport master (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

   // Loader side
   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

endinterface : instr_mem_loader_if

// File: rtl/instr_mem_loader.sv
// Program loader: accepts a framed byte stream (LEN_LO, LEN_HI, payload,
// CHK), writes the payload into instruction memory from address 0 and
// releases the CPU only once the checksum has been verified.
module instr_mem_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter bit BOOT_HOLD  = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   instr_mem_loader_if.slave  bus,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               cpu_run
);

   localparam int          CNT_W     = ADDR_WIDTH + 1;
   localparam int unsigned MEM_BYTES = 32'd1 << ADDR_WIDTH;

   state_t                 r_state;
   logic [LEN_WIDTH-1:0]   r_len;
   logic [CNT_W-1:0]       r_count;
   logic [SUM_WIDTH-1:0]   r_sum;
   logic                   r_we;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [7:0]             r_wdata;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_error;
   logic                   r_cpu_run;

   logic                   w_ready;
   logic                   w_xfer;
   logic [LEN_WIDTH-1:0]   w_len_full;
   logic                   w_last_data;

   // Ready is a pure decode of the registered state, independent of byte_valid
   always_comb begin
      // NOTE: default assignment first so no path leaves w_ready unassigned (no latch).
      w_ready = 1'b0;
      case (r_state)
         LEN_LO, LEN_HI, DATA, CHECK: w_ready = 1'b1;
         default:                     w_ready = 1'b0;
      endcase
   end

   assign w_xfer      = bus.byte_valid && w_ready;
   assign w_len_full  = {bus.byte_data, r_len[7:0]};
   // The byte being accepted now is payload byte number r_count+1
   assign w_last_data = (32'(r_count) + 32'd1) == 32'(r_len);

   // Frame sequencer and datapath: state, length, count, checksum, write port, status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_len     <= '0;
         r_count   <= '0;
         r_sum     <= '0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_cpu_run <= !BOOT_HOLD;
      end else begin
         // NOTE: non-blocking everywhere here; the write strobe defaults low so it pulses one cycle.
         r_we <= 1'b0;
         case (r_state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  r_state   <= LEN_LO;
                  r_done    <= 1'b0;
                  r_error   <= 1'b0;
                  r_sum     <= '0;
                  r_count   <= '0;
                  r_busy    <= 1'b1;
                  r_cpu_run <= 1'b0;
               end
            end
            LEN_LO: begin
               if (w_xfer) begin
                  r_len[7:0] <= bus.byte_data;
                  r_state    <= LEN_HI;
               end
            end
            LEN_HI: begin
               if (w_xfer) begin
                  r_len[15:8] <= bus.byte_data;
                  if (32'(w_len_full) > MEM_BYTES) begin
                     r_state   <= ERROR;
                     r_error   <= 1'b1;
                     r_busy    <= 1'b0;
                     r_cpu_run <= 1'b0;
                  end else if (w_len_full == '0) begin
                     r_state <= CHECK;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_xfer) begin
                  r_we    <= 1'b1;
                  r_addr  <= r_count[ADDR_WIDTH-1:0];
                  r_wdata <= bus.byte_data;
                  r_sum   <= r_sum + bus.byte_data;
                  r_count <= r_count + CNT_W'(1);
                  if (w_last_data) begin
                     r_state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (w_xfer) begin
                  r_busy <= 1'b0;
                  if (bus.byte_data == r_sum) begin
                     r_state   <= DONE;
                     r_done    <= 1'b1;
                     r_cpu_run <= 1'b1;
                  end else begin
                     r_state   <= ERROR;
                     r_error   <= 1'b1;
                     r_cpu_run <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready = w_ready;
   assign bus.mem_we     = r_we;
   assign bus.mem_addr   = r_addr;
   assign bus.mem_wdata  = r_wdata;
   assign busy           = r_busy;
   assign done           = r_done;
   assign error          = r_error;
   assign cpu_run        = r_cpu_run;

endmodule : instr_mem_loader
